// File: rtl/decoder3to8_hold.sv
// decoder3to8_hold
// Registered 3-to-8 one-hot decoder with a valid/ready input and a timed
// output pulse. It is the companion to the 8-to-3 one-hot encoder. Each
// accepted code drives one output line high for HOLD_CYCLES cycles. A
// one-entry pending buffer lets back-to-back codes appear on out with no
// idle cycle between them.
//
// Optional build macro: DEC_GAP_EN. When it is defined, a single all-zero
// GAP cycle follows every hold, so consecutive codes break before they make.
//
// Parameters:
//   HOLD_CYCLES  cycles each decoded line stays high (1..2^CNT_W)
//   CNT_W        width of the hold down-counter
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    in_code is valid this cycle
//   in_ready    block can accept a code this cycle
//   in_code     binary code to decode (0..7)
//   clear       synchronous abort; drops the active and pending codes
//   out         decoded one-hot output, or all zeros
//   out_active  high while out is non-zero
//   done        one-cycle pulse on the last cycle of each hold

module decoder3to8_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       clear,
  output logic [7:0] out,
  output logic       out_active,
  output logic       done
);

  // The counter holds the number of hold cycles left after the current one,
  // so it is loaded with HOLD_CYCLES-1 and the last cycle is cnt==0.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

`ifdef DEC_GAP_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t           state, state_n;
  logic [7:0]       out_n;
  logic             out_active_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pend_valid, pend_valid_n;
  logic [2:0]       pend_code, pend_code_n;
  logic             accept;
  logic             last;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    return 8'b0000_0001 << code;
  endfunction

  // State register. out and out_active are registered together so that
  // out_active always equals |out without a combinational OR on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out        <= 8'h00;
      out_active <= 1'b0;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_code  <= 3'd0;
    end else begin
      state      <= state_n;
      out        <= out_n;
      out_active <= out_active_n;
      cnt        <= cnt_n;
      pend_valid <= pend_valid_n;
      pend_code  <= pend_code_n;
    end
  end

  // Handshake and done strobe. in_ready looks only at the pending flag and
  // clear, never at in_valid, so an upstream block can wait on it safely.
  // done marks the last hold cycle and is still reported during a clear.
  always_comb begin
    in_ready = !pend_valid && !clear;
    accept   = in_valid && in_ready;
    last     = (state == HOLD) && (cnt == '0);
    done     = last;
  end

  // Next-state logic. clear overrides everything except reset. On the last
  // hold cycle a pending code beats a new input; a new input can only arrive
  // then when the pending buffer is empty, because in_ready is low otherwise.
  always_comb begin
    state_n      = state;
    out_n        = out;
    cnt_n        = cnt;
    pend_valid_n = pend_valid;
    pend_code_n  = pend_code;

    if (clear) begin
      state_n      = IDLE;
      out_n        = 8'h00;
      cnt_n        = '0;
      pend_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n = HOLD;
            out_n   = onehot(in_code);
            cnt_n   = RELOAD;
          end
        end

        HOLD: begin
          if (!last) begin
            cnt_n = cnt - CNT_W'(1);
            if (accept) begin
              pend_valid_n = 1'b1;
              pend_code_n  = in_code;
            end
          end else begin
`ifdef DEC_GAP_EN
            // Always break before the next code; a code arriving now waits
            // in the pending buffer for the gap cycle to finish.
            state_n = GAP;
            out_n   = 8'h00;
            if (accept) begin
              pend_valid_n = 1'b1;
              pend_code_n  = in_code;
            end
`else
            if (pend_valid) begin
              out_n        = onehot(pend_code);
              cnt_n        = RELOAD;
              pend_valid_n = 1'b0;
            end else if (accept) begin
              out_n = onehot(in_code);
              cnt_n = RELOAD;
            end else begin
              state_n = IDLE;
              out_n   = 8'h00;
            end
`endif
          end
        end

`ifdef DEC_GAP_EN
        GAP: begin
          if (pend_valid) begin
            state_n      = HOLD;
            out_n        = onehot(pend_code);
            cnt_n        = RELOAD;
            pend_valid_n = 1'b0;
          end else if (accept) begin
            state_n = HOLD;
            out_n   = onehot(in_code);
            cnt_n   = RELOAD;
          end else begin
            state_n = IDLE;
          end
        end
`endif

        default: begin
          state_n = IDLE;
          out_n   = 8'h00;
        end
      endcase
    end

    out_active_n = |out_n;
  end

endmodule

// File: tb/tb_decoder3to8_hold.sv
// tb_decoder3to8_hold
// Bench for decoder3to8_hold. Two instances share the inputs: one uses
// HOLD_CYCLES=4 and the other HOLD_CYCLES=1. Directed tables cover the
// documented scenarios; random runs compare against a timeline model that
// schedules the per-cycle output values of every accepted code.

`timescale 1ns/1ps

module tb_decoder3to8_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       clear;

  logic       in_ready0, out_active0, done0;
  logic [7:0] out0;
  logic       in_ready1, out_active1, done1;
  logic [7:0] out1;

  int total = 0;
  int bad   = 0;

`ifdef DEC_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder3to8_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .clear(clear), .out(out0),
    .out_active(out_active0), .done(done0)
  );

  decoder3to8_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_code(in_code), .clear(clear), .out(out1),
    .out_active(out_active1), .done(done1)
  );

  // One directed vector: inputs for a cycle plus the outputs expected in it.
  typedef struct {
    bit         v;
    logic [2:0] code;
    bit         clr;
    logic [7:0] eo;
    bit         ea;
    bit         ed;
    bit         er;
  } vec_t;

  vec_t tbl[$];

  // Timeline model: every future cycle of output is an entry in a queue.
  typedef struct packed {
    logic [7:0] val;
    bit         first;
    bit         last;
  } ent_t;

  ent_t mq[$];
  ent_t mcur;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] code, input bit clr);
    @(negedge clk);
    in_valid = v;
    in_code  = code;
    clear    = clr;
    #1;
  endtask

  task automatic getOuts(input int sel, output logic [7:0] o, output logic a,
                         output logic d, output logic r);
    if (sel == 0) begin
      o = out0; a = out_active0; d = done0; r = in_ready0;
    end else begin
      o = out1; a = out_active1; d = done1; r = in_ready1;
    end
  endtask

  task automatic doReset();
    logic [7:0] o;
    logic a, d, r;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; clear = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      getOuts(s, o, a, d, r);
      checkOutput($sformatf("reset%0d.out", s), 32'(o), 32'h0);
      checkOutput($sformatf("reset%0d.active", s), 32'(a), 32'h0);
      checkOutput($sformatf("reset%0d.done", s), 32'(d), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      getOuts(s, o, a, d, r);
      checkOutput($sformatf("reset%0d.ready", s), 32'(r), 32'h1);
    end
    mq.delete();
    mcur = '0;
  endtask

  task automatic runTable(input string name, input int sel);
    logic [7:0] o;
    logic a, d, r;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].code, tbl[i].clr);
      getOuts(sel, o, a, d, r);
      checkOutput($sformatf("%s.c%0d.out", name, i), 32'(o), 32'(tbl[i].eo));
      checkOutput($sformatf("%s.c%0d.active", name, i), 32'(a), 32'(tbl[i].ea));
      checkOutput($sformatf("%s.c%0d.done", name, i), 32'(d), 32'(tbl[i].ed));
      checkOutput($sformatf("%s.c%0d.ready", name, i), 32'(r), 32'(tbl[i].er));
    end
    tbl.delete();
  endtask

  // Random traffic against the timeline model. A code accepted while the
  // output is busy is appended after the scheduled cycles (after one zero
  // cycle when gaps are enabled); the block is busy-pending while some code
  // in the future timeline has not started yet.
  task automatic randomRun(input int sel, input int hold, input int n);
    logic [7:0] o;
    logic a, d, r;
    bit v, clr, pend, exp_ready, acc;
    logic [2:0] code;
    ent_t e;
    doReset();
    for (int i = 0; i < n; i++) begin
      v    = 1'($urandom_range(0, 1));
      code = 3'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 15) == 0);
      applyStimulus(v, code, clr);
      pend = 1'b0;
      foreach (mq[k]) if (mq[k].first) pend = 1'b1;
      exp_ready = !clr && !pend;
      acc = v && exp_ready;
      getOuts(sel, o, a, d, r);
      checkOutput($sformatf("rnd%0d.c%0d.out", sel, i), 32'(o), 32'(mcur.val));
      checkOutput($sformatf("rnd%0d.c%0d.active", sel, i), 32'(a), 32'(mcur.val != 8'h00));
      checkOutput($sformatf("rnd%0d.c%0d.done", sel, i), 32'(d), 32'(mcur.last));
      checkOutput($sformatf("rnd%0d.c%0d.ready", sel, i), 32'(r), 32'(exp_ready));
      if (clr) begin
        mq.delete();
      end else if (acc) begin
        if (GAP_EN && mcur.val != 8'h00) mq.push_back('0);
        for (int h = 0; h < hold; h++) begin
          e.val   = 8'(1 << code);
          e.first = (h == 0);
          e.last  = (h == hold - 1);
          mq.push_back(e);
        end
      end
      mcur = (mq.size() > 0) ? mq.pop_front() : '0;
    end
  endtask

  initial begin
    logic [7:0] o;
    logic a, d, r;
    logic [7:0] one;
    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; clear = 1'b0;
    mcur = '0;

`ifndef DEC_GAP_EN
    // Single code 5 with HOLD_CYCLES=4.
    doReset();
    tbl.push_back('{1, 3'd5, 0, 8'h00, 0, 0, 1});
    for (int i = 1; i <= 4; i++) tbl.push_back('{0, 3'd0, 0, 8'h20, 1, (i == 4), 1});
    tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("single", 0);

    // Code 0 then code 7 into the pending buffer; contiguous output.
    doReset();
    tbl.push_back('{1, 3'd0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{1, 3'd7, 0, 8'h01, 1, 0, 1});
    tbl.push_back('{0, 3'd0, 0, 8'h01, 1, 0, 0});
    tbl.push_back('{0, 3'd0, 0, 8'h01, 1, 0, 0});
    tbl.push_back('{0, 3'd0, 0, 8'h01, 1, 1, 0});
    for (int i = 5; i <= 8; i++) tbl.push_back('{0, 3'd0, 0, 8'h80, 1, (i == 8), 1});
    tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("pending", 0);

    // Code 6 bypasses on the last hold cycle of code 2.
    doReset();
    tbl.push_back('{1, 3'd2, 0, 8'h00, 0, 0, 1});
    for (int i = 1; i <= 3; i++) tbl.push_back('{0, 3'd0, 0, 8'h04, 1, 0, 1});
    tbl.push_back('{1, 3'd6, 0, 8'h04, 1, 1, 1});
    for (int i = 5; i <= 8; i++) tbl.push_back('{0, 3'd0, 0, 8'h40, 1, (i == 8), 1});
    tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("bypass", 0);

    // Clear drops both the active code 3 and the pending code 1.
    doReset();
    tbl.push_back('{1, 3'd3, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{1, 3'd1, 0, 8'h08, 1, 0, 1});
    tbl.push_back('{0, 3'd0, 1, 8'h08, 1, 0, 0});
    for (int i = 3; i <= 7; i++) tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("clear", 0);

    // Asynchronous reset in the middle of a hold, then a fresh code 4.
    doReset();
    tbl.push_back('{1, 3'd5, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 3'd0, 0, 8'h20, 1, 0, 1});
    tbl.push_back('{0, 3'd0, 0, 8'h20, 1, 0, 1});
    runTable("prerst", 0);
    #2 rst = 1'b1;
    #1;
    getOuts(0, o, a, d, r);
    checkOutput("asyncrst.out", 32'(o), 32'h0);
    checkOutput("asyncrst.active", 32'(a), 32'h0);
    checkOutput("asyncrst.done", 32'(d), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tbl.push_back('{1, 3'd4, 0, 8'h00, 0, 0, 1});
    for (int i = 1; i <= 4; i++) tbl.push_back('{0, 3'd0, 0, 8'h10, 1, (i == 4), 1});
    tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("postrst", 0);

    // HOLD_CYCLES=1 streaming 0..7: out walks one bit per cycle.
    doReset();
    for (int i = 0; i < 8; i++) begin
      one = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
      tbl.push_back('{1, 3'(i), 0, one, (i != 0), (i != 0), 1});
    end
    tbl.push_back('{0, 3'd0, 0, 8'h80, 1, 1, 1});
    tbl.push_back('{0, 3'd0, 0, 8'h00, 0, 0, 1});
    runTable("stream1", 1);
`endif

    randomRun(0, 4, 500);
    randomRun(1, 1, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder3to8_hold.md
Name: decoder3to8_hold

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready input and a timed output pulse. It is the companion to the team's 8-to-3 one-hot encoder.
- Each accepted 3-bit code drives exactly one output line high for HOLD_CYCLES clock cycles, then returns to zero.
- A one-entry pending buffer lets back-to-back codes produce contiguous output.
- Used as a select/strobe driver (LED or segment select, channel enable) downstream of the encoder.

Parameters:
- HOLD_CYCLES, 4, cycles each decoded line stays high; legal range 1..2^CNT_W.
- CNT_W, 8, width of the hold down-counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- in_code  input  3  binary code to decode (0..7)
- clear  input  1  synchronous abort; drops the active and pending codes
- out  output  8  decoded one-hot output, or all zeros
- out_active  output  1  high while out is non-zero
- done  output  1  one-cycle pulse on the last cycle of each hold

Behaviour:
- Accept: in_valid && in_ready sampled at a rising edge of clk. Handshake activity while rst is high is ignored.
- in_ready = !pend_valid && !clear. It is combinational from registers and clear; it does not depend on in_valid.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, out=8'h00, out_active=0, done=0, cnt=0, pend_valid=0.
  - in_ready=1 as soon as rst is low.
- States: IDLE, HOLD (GAP only with the optional feature).
- IDLE, on accept: next cycle state=HOLD, out=1<<in_code, cnt=HOLD_CYCLES-1. Latency is one cycle from the accepting edge.
- HOLD, not last cycle (cnt!=0):
  - cnt decrements; out is unchanged.
  - An accept stores the code in the pending buffer (pend_valid=1).
- HOLD, last cycle (cnt==0): done=1 combinationally. At the edge ending the cycle, priority is:
  - pend_valid: load the pending code into out, reload cnt, clear pend_valid.
  - Otherwise, accept this cycle: bypass the input directly into out and reload cnt.
  - Otherwise: state=IDLE, out=0.
- Each code is active for exactly HOLD_CYCLES cycles. Consecutive codes are contiguous with no zero cycle between them.
- Pending full on the last cycle: in_ready=0, so there is no simultaneous accept; the pending code wins.
- clear=1 (priority below rst):
  - Next cycle state=IDLE, out=0, cnt=0, pend_valid=0.
  - done is still driven if the current cycle is a last cycle.
  - No accept can occur in a clear cycle.
- HOLD_CYCLES=1: every HOLD cycle is a last cycle, so done is high on every active cycle.
- Invariants:
  - out is either 0 or exactly one bit set.
  - out_active == |out, registered alongside out.
  - done implies out_active.
  - pend_valid implies state!=IDLE.
- in_code width is exact and every value 0..7 is legal; no X is ever driven on out.

Optional Feature:
- Macro: DEC_GAP_EN.
- Defined:
  - The last HOLD cycle always transitions to GAP. GAP drives out=0, out_active=0, done=0 for exactly one cycle.
  - Leaving GAP: if pend_valid, load pending → HOLD; else if accept this cycle, bypass → HOLD; else IDLE.
  - Accepts during HOLD and GAP follow the pending rules above.
  - Back-to-back codes are separated by exactly one zero cycle (break-before-make).
- Undefined: the GAP state and its logic are absent, and the behaviour is as described above.

Test Plan:
1. Reset; in_code=5 accepted at edge 0.
   - out=8'h20, out_active=1 on cycles 1-4; done only on cycle 4.
   - out=8'h00 and state IDLE on cycle 5.
2. Code 0 accepted at edge 0; code 7 held valid from cycle 1.
   - 7 accepted at edge 1 into pending; in_ready=0 on cycles 2-4.
   - out=8'h01 on cycles 1-4, then 8'h80 on cycles 5-8 with no zero gap; done on cycles 4 and 8.
3. Code 2 accepted; code 6 presented only on cycle 4 (last hold cycle, pending empty).
   - Bypass: out=8'h04 on cycles 1-4, 8'h40 on cycles 5-8.
4. Code 3 active, code 1 pending; clear=1 on cycle 2.
   - Cycle 3: out=0, out_active=0, in_ready=1, pend_valid=0; code 1 never appears; no done.
5. rst asserted mid-hold with no clock edge.
   - out=0, out_active=0, done=0 immediately; after release, code 4 decodes normally to 8'h10.
6. HOLD_CYCLES=1, codes 0..7 streamed with in_valid held high.
   - out walks 8'h01, 8'h02, … 8'h80 one per cycle, done=1 every cycle.
   - With DEC_GAP_EN: 8'h01, 0, 8'h02, 0, …; done only on non-zero cycles.
